// File: rtl/eq_run_sequencer_pkg.sv
// Shared types and default address map for the equalizer run sequencer.
package eq_seq_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, FIN} seq_state_t;

    localparam logic [31:0] IMG_BASE_D  = 32'h0000_1000;
    localparam logic [31:0] OUT_BASE_D  = 32'h0000_5000;
    localparam logic [31:0] DONE_ADDR_D = 32'h0000_0FFC;

    // Byte address of word number idx in a pixel buffer starting at base.
    function automatic logic [31:0] pix_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/eq_run_sequencer_if.sv
// Pixel stream, CPU data port, dmem port and status lines of the run sequencer.
interface eq_run_sequencer_if;

    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        cpu_reset;
    logic        cpu_mem_write;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        timeout;

    // The sequencer's view.
    modport master (
        input  start, in_valid, in_data, out_ready,
        input  cpu_mem_write, cpu_adr, cpu_wdata, mem_rdata,
        output in_ready, out_valid, out_data, cpu_reset, cpu_rdata,
        output mem_we, mem_adr, mem_wdata, busy, done, timeout
    );

    // The surrounding system's view: source, sink, CPU and dmem.
    modport slave (
        output start, in_valid, in_data, out_ready,
        output cpu_mem_write, cpu_adr, cpu_wdata, mem_rdata,
        input  in_ready, out_valid, out_data, cpu_reset, cpu_rdata,
        input  mem_we, mem_adr, mem_wdata, busy, done, timeout
    );

endinterface

// File: rtl/eq_run_sequencer_dmem_port_mux.sv
// Chooses whether the CPU or the sequencer drives the data memory port.
module dmem_port_mux (
    input  logic        sel_cpu,
    input  logic        cpu_we,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wdata,
    input  logic        seq_we,
    input  logic [31:0] seq_adr,
    input  logic [31:0] seq_wdata,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata
);

    assign mem_we    = sel_cpu ? cpu_we    : seq_we;
    assign mem_adr   = sel_cpu ? cpu_adr   : seq_adr;
    assign mem_wdata = sel_cpu ? cpu_wdata : seq_wdata;

endmodule

// File: rtl/eq_run_sequencer.sv
// Loads an image into dmem, runs the CPU until its mailbox store, then streams
// the result out; a watchdog aborts runs that never reach the mailbox.
module eq_run_sequencer
    import eq_seq_pkg::*;
#(
    parameter int unsigned N_PIXELS       = 4096,
    parameter logic [31:0] IMG_BASE       = IMG_BASE_D,
    parameter logic [31:0] OUT_BASE       = OUT_BASE_D,
    parameter logic [31:0] DONE_ADDR      = DONE_ADDR_D,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input logic               clk,
    input logic               reset,
    eq_run_sequencer_if.master bus
);

    localparam int IDX_W = $clog2(N_PIXELS + 1);
    localparam int RC_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PIXELS - 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(TIMEOUT_CYCLES - 1);

    seq_state_t       state;
    logic [IDX_W-1:0] idx;
    logic [RC_W-1:0]  run_cnt;
    logic             cpu_reset_r;
    logic             done_r;
    logic             timeout_r;
    logic             mailbox_hit;
    logic             seq_we;
    logic [31:0]      seq_adr;
    logic [31:0]      seq_wdata;

    assign mailbox_hit = bus.cpu_mem_write && (bus.cpu_adr == DONE_ADDR);

    always_comb begin
        seq_we    = 1'b0;
        seq_adr   = '0;
        seq_wdata = '0;
        case (state)
            LOAD: begin
                if (bus.in_valid) begin
                    seq_we    = 1'b1;
                    seq_adr   = pix_addr(IMG_BASE, 32'(idx));
                    seq_wdata = {24'b0, bus.in_data};
                end
            end
            DUMP:    seq_adr = pix_addr(OUT_BASE, 32'(idx));
            default: ;
        endcase
    end

    dmem_port_mux u_mux (
        .sel_cpu   (state == RUN),
        .cpu_we    (bus.cpu_mem_write),
        .cpu_adr   (bus.cpu_adr),
        .cpu_wdata (bus.cpu_wdata),
        .seq_we    (seq_we),
        .seq_adr   (seq_adr),
        .seq_wdata (seq_wdata),
        .mem_we    (bus.mem_we),
        .mem_adr   (bus.mem_adr),
        .mem_wdata (bus.mem_wdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            run_cnt     <= '0;
            cpu_reset_r <= 1'b1;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (bus.start) begin
                        state     <= LOAD;
                        idx       <= '0;
                        done_r    <= 1'b0;
                        timeout_r <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        if (idx == IDX_LAST) begin
                            state       <= RUN;
                            idx         <= '0;
                            run_cnt     <= '0;
                            cpu_reset_r <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (run_cnt != '1) run_cnt <= run_cnt + 1'b1;
                    // The mailbox store takes priority over a watchdog expiring in the same cycle.
                    if (mailbox_hit) begin
                        state       <= DUMP;
                        cpu_reset_r <= 1'b1;
                    end else if (run_cnt == RC_LAST) begin
                        state       <= FIN;
                        timeout_r   <= 1'b1;
                        cpu_reset_r <= 1'b1;
                    end
                end
                DUMP: begin
                    if (bus.out_ready) begin
                        if (idx == IDX_LAST) begin
                            state  <= FIN;
                            idx    <= '0;
                            done_r <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == LOAD);
    assign bus.out_valid = (state == DUMP);
    assign bus.out_data  = (state == DUMP) ? bus.mem_rdata[7:0] : 8'h00;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.cpu_reset = cpu_reset_r;
    assign bus.busy      = (state == LOAD) || (state == RUN) || (state == DUMP);
    assign bus.done      = done_r;
    assign bus.timeout   = timeout_r;

endmodule
